// File: rtl/map_ram_arbiter.sv
// map_ram_arbiter: round-robin multi-channel map RAM with self-clearing storage
// Ports: clk_i rising-edge clock; rst_ni async active-low reset; clear_i soft clear (SERVE only);
//   req_i/we_i per-channel request and write enable; addr_i/wdata_i per-channel packed fields;
//   grant_o one-hot access pulse; rvalid_o one-hot read-result pulse; rdata_o last read word;
//   busy_o high while the memory is being cleared.
module map_ram_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int N_CH = 3,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic [N_CH-1:0]          req_i,
  input  logic [N_CH-1:0]          we_i,
  input  logic [N_CH*ADDR_W-1:0]   addr_i,
  input  logic [N_CH*DATA_W-1:0]   wdata_i,
  output logic [N_CH-1:0]          grant_o,
  output logic [N_CH-1:0]          rvalid_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     busy_o
);
  localparam int CW = $clog2(N_CH);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {CLEAR, SERVE} state_t;
  state_t state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [CW-1:0] ptr_q, win, idx;
  logic [N_CH-1:0] elig, win_oh, grant_q, rvalid_q;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata, rdata_q;
  logic win_v, win_we, do_acc, busy_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  // a channel just granted is masked so its still-high req cannot win twice
  assign elig = req_i & ~grant_q;
  always_comb begin
    win_v = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = CW'((int'(ptr_q) + k) % N_CH);
      win = (!win_v && elig[idx]) ? idx : win;
      win_v = win_v | elig[idx];
    end
  end
  assign win_oh = N_CH'(1) << win;
  assign win_we = we_i[win];
  assign win_addr = addr_i[win*ADDR_W +: ADDR_W];
  assign win_wdata = wdata_i[win*DATA_W +: DATA_W];
  assign do_acc = (state_q == SERVE) && !clear_i && win_v;
  // storage has no reset; contents become defined by the CLEAR sweep
  always_ff @(posedge clk_i) begin
    if (state_q == CLEAR) mem_q[cnt_q] <= INIT_VAL;
    else if (do_acc && win_we) mem_q[win_addr] <= win_wdata;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      ptr_q <= CW'(N_CH - 1);
      grant_q <= '0;
      rvalid_q <= '0;
      rdata_q <= '0;
      busy_q <= 1'b1;
    end else begin
      grant_q <= '0;
      rvalid_q <= '0;
      if (state_q == CLEAR) begin
        cnt_q <= cnt_q + 1'b1;
        if (&cnt_q) begin
          state_q <= SERVE;
          busy_q <= 1'b0;
        end
      end else if (clear_i) begin
        state_q <= CLEAR;
        cnt_q <= '0;
        busy_q <= 1'b1;
      end else if (do_acc) begin
        grant_q <= win_oh;
        ptr_q <= win;
        if (!win_we) begin
          rvalid_q <= win_oh;
          rdata_q <= mem_q[win_addr];
        end
      end
    end
  end
  assign grant_o = grant_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o = rdata_q;
  assign busy_o = busy_q;
endmodule

// File: tb/tb_map_ram_arbiter.sv
// tb_map_ram_arbiter: scoreboard bench with a behavioural memory/arbiter model
module tb_map_ram_arbiter;
  localparam int N = 3, AW = 4, DW = 32, D = 16;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [N-1:0] req = '0, we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0] grant, rvalid;
  logic [DW-1:0] rdata;
  logic busy;
  typedef struct {logic [N-1:0] g; logic [N-1:0] rv; logic [DW-1:0] rd; logic b;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int total = 0, bad = 0;
  int m_clr, m_ptr;
  logic [N-1:0] m_grant;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_mem [D];

  map_ram_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .grant_o(grant), .rvalid_o(rvalid),
    .rdata_o(rdata), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("grant", DW'(grant), DW'(mon_e.g));
      chk("rvalid", DW'(rvalid), DW'(mon_e.rv));
      chk("rdata", rdata, mon_e.rd);
      chk("busy", DW'(busy), DW'(mon_e.b));
    end
  end

  task automatic model_reset();
    m_clr = D;
    m_ptr = N - 1;
    m_grant = '0;
    m_rdata = '0;
    for (int a = 0; a < D; a++) m_mem[a] = '0;
    q.delete();
  endtask

  // predicts what the DUT shows in the cycle after the upcoming rising edge
  task automatic step();
    logic [N-1:0] g, rv;
    int c, a;
    exp_t e;
    g = '0;
    rv = '0;
    if (m_clr > 0) m_clr--;
    else if (clear) begin
      m_clr = D;
      for (int i = 0; i < D; i++) m_mem[i] = '0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (g == 0 && req[c] && !m_grant[c]) begin
          g[c] = 1'b1;
          m_ptr = c;
          a = int'(addr[c*AW +: AW]);
          if (we[c]) m_mem[a] = wdata[c*DW +: DW];
          else begin
            rv[c] = 1'b1;
            m_rdata = m_mem[a];
          end
        end
      end
    end
    m_grant = g;
    e.g = g;
    e.rv = rv;
    e.rd = m_rdata;
    e.b = (m_clr > 0);
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      step();
      @(negedge clk);
    end
  endtask

  task automatic set_ch(input int c, input logic r, input logic w, input int a, input logic [DW-1:0] d);
    req[c] = r;
    we[c] = w;
    addr[c*AW +: AW] = AW'(a);
    wdata[c*DW +: DW] = d;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int c = 0; c < N; c++) set_ch(c, 1'b1, 1'b0, (c == 0) ? 5 : c, '0);
    repeat (3) @(negedge clk);
    chk("rst_grant", DW'(grant), '0);
    chk("rst_rvalid", DW'(rvalid), '0);
    chk("rst_rdata", rdata, '0);
    chk("rst_busy", DW'(busy), 1);
    rst_n = 1'b1;
    model_reset();
    tick(17);
    chk("first_grant", DW'(grant), 1);
    chk("first_rvalid", DW'(rvalid), 1);
    chk("first_rdata", rdata, '0);
    req = '0;
    tick(2);
    set_ch(1, 1'b1, 1'b1, 3, 32'hDEADBEEF);
    tick(1);
    chk("wr_grant", DW'(grant), 2);
    req = '0;
    set_ch(2, 1'b1, 1'b0, 3, '0);
    tick(1);
    chk("rd_grant", DW'(grant), 4);
    chk("rd_rvalid", DW'(rvalid), 4);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    req = '0;
    tick(2);
    for (int c = 0; c < N; c++) begin
      set_ch(0, 1'b1, 1'b1, c, 32'h100 + c);
      tick(1);
      req = '0;
      tick(1);
    end
    for (int c = 0; c < N; c++) set_ch(c, 1'b1, 1'b0, c, '0);
    tick(9);
    req = '0;
    tick(1);
    set_ch(0, 1'b1, 1'b0, 2, '0);
    tick(6);
    req = '0;
    tick(1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", DW'(grant), '0);
    chk("mid_rst_rvalid", DW'(rvalid), '0);
    chk("mid_rst_rdata", rdata, '0);
    chk("mid_rst_busy", DW'(busy), 1);
    @(negedge clk);
    for (int c = 0; c < N; c++) set_ch(c, 1'b1, 1'b0, c + 4, '0);
    rst_n = 1'b1;
    model_reset();
    tick(16);
    req = '0;
    tick(3);
    for (int a = 0; a < D; a++) begin
      set_ch(1, 1'b1, 1'b1, a, $urandom | 32'h1);
      tick(1);
      req = '0;
      tick(1);
    end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    for (int c = 0; c < N; c++) set_ch(c, 1'b1, 1'b0, c + 7, '0);
    tick(16);
    req = '0;
    tick(2);
    for (int a = 0; a < D; a++) begin
      set_ch(2, 1'b1, 1'b0, a, '0);
      tick(1);
      req = '0;
      tick(1);
    end
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < N; c++) begin
        if (m_grant[c]) req[c] = 1'b0;
        if (!req[c] && $urandom_range(1, 0) == 1)
          set_ch(c, 1'b1, 1'($urandom_range(1, 0)), int'($urandom_range(D - 1, 0)), $urandom);
      end
      clear = ($urandom_range(79, 0) == 0);
      tick(1);
    end
    clear = 1'b0;
    req = '0;
    tick(20);
    @(negedge clk);
    chk("queue_drained", DW'(q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
